// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
// Optional leading-zero blanking output is enabled with macro BIN2BCD_LZB_EN.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

  // Counter must hold 0..BIN_W-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int bin_w);
    return (bin_w > 1) ? $clog2(bin_w) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Per-digit add-3 correction, no carry into neighbouring digits
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter, one input bit per clock, with
// valid/ready handshakes. Define BIN2BCD_LZB_EN to add the digit_en output.
module bin2bcd_seq_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  busy
`ifdef BIN2BCD_LZB_EN
  ,
  output logic [DIGITS-1:0]     digit_en
`endif
);

  localparam int BCD_W = bcd_width(DIGITS);
  localparam int CNT_W = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic [BIN_W-1:0]   shreg_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [BCD_W-1:0]   adj_s;
  logic [BCD_W-1:0]   shift_bcd_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_r[4*g +: 4]),
      .dout (adj_s[4*g +: 4])
    );
  end

  // The adjusted top bit is what falls off the accumulator on this shift.
  assign shift_bcd_s = {adj_s[BCD_W-2:0], shreg_r[BIN_W-1]};

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, handshake flags and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      shreg_r     <= '0;
      bcd_r       <= '0;
      cnt_r       <= '0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s == SHIFT);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shreg_r <= bin;
            bcd_r   <= '0;
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
          end
        end
        SHIFT: begin
          bcd_r   <= shift_bcd_s;
          shreg_r <= {shreg_r[BIN_W-2:0], 1'b0};
          ovf_r   <= ovf_r | adj_s[BCD_W-1];
          cnt_r   <= cnt_r + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign bcd       = bcd_r;
  assign ovf       = ovf_r;

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] digit_en_r;
  logic [DIGITS-1:0] digit_en_s;

  // A digit is shown if it or any more significant digit is nonzero
  always_comb begin
    logic any_s;
    any_s      = 1'b0;
    digit_en_s = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_s         = any_s | (shift_bcd_s[4*k +: 4] != 4'd0);
      digit_en_s[k] = any_s;
    end
    digit_en_s[0] = 1'b1;
  end

  // Capture the blanking mask together with the final shift
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_en_r <= '0;
    end else if (state_r == IDLE && in_valid) begin
      digit_en_r <= '0;
    end else if (state_r == SHIFT && cnt_r == CNT_LAST) begin
      digit_en_r <= digit_en_s;
    end
  end

  assign digit_en = digit_en_r;
`endif

endmodule
